// File: rtl/exp_pkg.sv
// Shared constants and coefficient helper for the Taylor-series e^x engine.
package exp_pkg;

    localparam int unsigned W  = 16;
    localparam int unsigned F  = 14;
    localparam int unsigned N  = 8;
    localparam int unsigned CW = $clog2(N);

    // floor(2^frac / (k+1)): reciprocal scale applied to the running term
    function automatic int unsigned coef(input int unsigned k, input int unsigned frac = F);
        return (32'd1 << frac) / (k + 32'd1);
    endfunction

endpackage

// File: rtl/exp_coef_rom.sv
// Combinational reciprocal table: counter value k -> floor(2^F/(k+1)).
module exp_coef_rom
    import exp_pkg::*;
#(
    parameter int unsigned W = exp_pkg::W,
    parameter int unsigned F = exp_pkg::F,
    parameter int unsigned N = exp_pkg::N,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic [CW-1:0] idx,
    output logic [W-1:0]  val_c
);

    // Indices past N-1 (only reachable when N is not a power of two) read as zero
    always_comb begin
        val_c = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx == CW'(k)) begin
                val_c = W'(coef(k, F));
            end
        end
    end

endmodule

// File: rtl/exp_datapath.sv
// Fixed-point datapath for the e^x engine: x, t, r registers, term counter c,
// one shared multiplier and a saturating accumulator.
module exp_datapath
    import exp_pkg::*;
#(
    parameter int unsigned W = exp_pkg::W,
    parameter int unsigned F = exp_pkg::F,
    parameter int unsigned N = exp_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic         initx,
    input  logic         ldx,
    input  logic         initt,
    input  logic         ldt,
    input  logic         initr,
    input  logic         ldr,
    input  logic         ldc,
    input  logic         enc,
    input  logic         s,
    output logic         co,
    output logic [W-1:0] y
);

    localparam int unsigned CW  = $clog2(N);
    localparam int unsigned PW  = 2 * W;
    localparam int unsigned SW  = W + 1;
    localparam logic [W-1:0] ONE = W'(32'd1 << F);

    logic [W-1:0]  x;
    logic [W-1:0]  t;
    logic [W-1:0]  r;
    logic [CW-1:0] c;

    logic [W-1:0]  coef_c;
    logic [W-1:0]  mul_b_c;
    logic [W-1:0]  t_mul_c;
    logic [SW-1:0] sum_c;
    logic [W-1:0]  r_sum_c;

    exp_coef_rom #(
        .W (W),
        .F (F),
        .N (N)
    ) u_coef_rom (
        .idx   (c),
        .val_c (coef_c)
    );

    // Shared multiplier: full-width product, drop F fraction bits, keep low W
    always_comb begin
        mul_b_c = s ? coef_c : x;
        t_mul_c = W'((PW'(t) * PW'(mul_b_c)) >> F);
    end

    // Saturating accumulate
    always_comb begin
        sum_c   = SW'(r) + SW'(t);
        r_sum_c = sum_c[W] ? '1 : sum_c[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
        end else if (initx) begin
            x <= '0;
        end else if (ldx) begin
            x <= x_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t <= '0;
        end else if (initt) begin
            t <= ONE;
        end else if (ldt) begin
            t <= t_mul_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
        end else if (initr) begin
            r <= '0;
        end else if (ldr) begin
            r <= r_sum_c;
        end
    end

    // Free-running wrap at 2^CW-1; the controller stops on co
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c <= '0;
        end else if (ldc) begin
            c <= '0;
        end else if (enc) begin
            c <= c + CW'(1);
        end
    end

    assign co = (c == CW'(N - 1));
    assign y  = r;

endmodule

// File: tb/tb_exp_datapath.sv
// Directed and randomized checks of exp_datapath against an integer reference model.
module tb_exp_datapath;

    localparam int unsigned W  = 16;
    localparam int unsigned F  = 14;
    localparam int unsigned N  = 8;
    localparam int unsigned CW = 3;

    localparam logic [8:0] IX = 9'h100;
    localparam logic [8:0] LX = 9'h080;
    localparam logic [8:0] IT = 9'h040;
    localparam logic [8:0] LT = 9'h020;
    localparam logic [8:0] IR = 9'h010;
    localparam logic [8:0] LR = 9'h008;
    localparam logic [8:0] LC = 9'h004;
    localparam logic [8:0] EC = 9'h002;
    localparam logic [8:0] S1 = 9'h001;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] x_in;
    logic         initx, ldx, initt, ldt, initr, ldr, ldc, enc, s;
    logic         co;
    logic [W-1:0] y;

    int errors = 0;
    int checks = 0;

    int unsigned mx, mt, mr, mc;

    always #5 clk = ~clk;

    exp_datapath dut (
        .clk   (clk),
        .rst   (rst),
        .x_in  (x_in),
        .initx (initx),
        .ldx   (ldx),
        .initt (initt),
        .ldt   (ldt),
        .initr (initr),
        .ldr   (ldr),
        .ldc   (ldc),
        .enc   (enc),
        .s     (s),
        .co    (co),
        .y     (y)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_coef(input int unsigned k);
        return (1 << F) / (k + 1);
    endfunction

    // e^x term arithmetic in plain integers, applied at one clock edge
    task automatic model_edge();
        int unsigned nx, nt, nr, nc;
        longint unsigned p;
        nx = initx ? 0 : (ldx ? int'(x_in) : mx);
        p  = longint'(mt) * longint'(s ? ref_coef(mc) : mx);
        nt = initt ? (1 << F) : (ldt ? int'((p >> F) % (longint'(1) << W)) : mt);
        nr = initr ? 0 : (ldr ? ((mr + mt > 65535) ? 65535 : mr + mt) : mr);
        nc = ldc ? 0 : (enc ? (mc + 1) % (1 << CW) : mc);
        mx = nx; mt = nt; mr = nr; mc = nc;
    endtask

    task automatic model_clear();
        mx = 0; mt = 0; mr = 0; mc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check("y", 32'(y), mr);
        check("co", 32'(co), (mc == N - 1) ? 1 : 0);
        check("x", 32'(dut.x), mx);
        check("t", 32'(dut.t), mt);
        check("c", 32'(dut.c), mc);
    endtask

    task automatic go(input logic [8:0] v);
        {initx, ldx, initt, ldt, initr, ldr, ldc, enc, s} = v;
        tick();
    endtask

    initial begin
        int d;
        int iters;
        rst  = 1'b0;
        x_in = '0;
        {initx, ldx, initt, ldt, initr, ldr, ldc, enc, s} = '0;
        model_clear();
        #12;
        check("reset_y", 32'(y), 0);
        check("reset_co", 32'(co), 0);
        rst = 1'b1;
        go('0);

        // Load priority
        x_in = 16'h2000;
        go(LX);
        go(IX | LX);
        check("prio_x", 32'(dut.x), 0);
        go(IT | LT);
        check("prio_t", 32'(dut.t), 32'h4000);
        go(EC);
        go(EC);
        go(LC | EC);
        check("prio_c", 32'(dut.c), 0);

        // Single products
        x_in = 16'h2000;
        go(LX | IT);
        go(LT);
        check("mul_x", 32'(dut.t), 32'h2000);
        go(EC);
        go(LT | S1);
        check("mul_coef", 32'(dut.t), 32'h1000);

        // Counter run-up and wrap
        go(LC);
        for (int i = 1; i <= 7; i++) begin
            go(EC);
            check("cnt_co", 32'(co), (i == 7) ? 1 : 0);
        end
        go(EC);
        check("cnt_wrap_c", 32'(dut.c), 0);
        check("cnt_wrap_co", 32'(co), 0);

        // Saturation: build r=0xF000, then add 1.0
        go(IR | IT);
        go(LR);
        go(LR);
        go(LR);
        x_in = 16'h3000;
        go(LX);
        go(LT);
        go(LR);
        check("sat_pre", 32'(y), 32'hF000);
        go(IT);
        go(LR);
        check("sat_y", 32'(y), 32'hFFFF);

        // Same-cycle ldt/ldr accumulates the old t
        go(IR | IT);
        go(LR | LT);
        check("old_t", 32'(y), 32'h4000);

        // Full series for x = 0.5 with the controller's strobe sequence
        x_in = 16'h2000;
        go(LX | IT | IR | LC);
        go(LR);
        iters = 0;
        while (!co && iters < 40) begin
            go(LT | S1);
            go(LT);
            go(LR | EC);
            iters++;
        end
        check("series_co", 32'(co), 1);
        check("series_iters", 32'(iters), 7);
        check("series_y", 32'(y), 32'h6983);
        d = int'(y) - 32'h6985;
        if (d < 0) d = -d;
        check("series_tol", (d <= 2) ? 32'd1 : 32'd0, 1);

        // Asynchronous reset mid-computation with every strobe high
        x_in = 16'h1234;
        go(9'h1FF);
        go(LX | LT | LR | EC);
        #3;
        rst = 1'b0;
        model_clear();
        {initx, ldx, initt, ldt, initr, ldr, ldc, enc, s} = 9'h1FF;
        #1;
        check("areset_y", 32'(y), 0);
        check("areset_co", 32'(co), 0);
        tick();
        tick();
        check("areset_hold_t", 32'(dut.t), 0);
        rst = 1'b1;
        go('0);

        // Randomized strobe/operand mix
        for (int i = 0; i < 400; i++) begin
            x_in = W'($urandom);
            go(9'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
